cmd_dispatcher: RTL and testbench

Consumer of the 80-bit EBI command FIFO. Pops one command at a time and decodes it into target, opcode, start time and payload. Holds the command until `global_clock` reaches its start time, then issues it as a one-cycle write strobe on the pin-controller command bus. Sits between the command FIFO and the pin controllers, timed by the EBI-owned global clock.

---
 rtl/mecobo_pkg.sv | 25 ++
 rtl/sched_time_cmp.sv | 21 ++
 rtl/cmd_dispatcher.sv | 110 +++++++++++
 tb/tb_cmd_dispatcher.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mecobo_pkg.sv
// Shared definitions for the EBI command path: command word layout,
// opcode constants and the dispatcher state encoding.
package mecobo_pkg;

  localparam int CMD_W       = 80;

  localparam int CMD_ADDR_HI = 79;
  localparam int CMD_ADDR_LO = 72;
  localparam int CMD_OP_HI   = 71;
  localparam int CMD_OP_LO   = 64;
  localparam int CMD_TIME_HI = 63;
  localparam int CMD_TIME_LO = 32;
  localparam int CMD_DATA_HI = 31;
  localparam int CMD_DATA_LO = 0;

  localparam logic [7:0] OP_NOP = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_WAIT     = 2'd2,
    ST_DISPATCH = 2'd3
  } dispatch_state_t;

endpackage

// File: rtl/sched_time_cmp.sv
// Wrap-aware start-time comparator. A start time of zero means "run now"
// and is never reported as late.
module sched_time_cmp (
  input  logic [31:0] global_clock_i,
  input  logic [31:0] start_time_i,
  output logic        due_o,
  output logic        late_o
);

  logic [31:0] diff;
  logic        immediate;

  // Sign of (now - start) decides past/future across the 32-bit wrap.
  always_comb begin
    diff      = global_clock_i - start_time_i;
    immediate = (start_time_i == 32'd0);
    due_o     = immediate || !diff[31];
    late_o    = !immediate && !diff[31] && (diff != 32'd0);
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// Pops timed commands from the EBI command FIFO, holds each until its
// start time, then issues it as a one-cycle strobe to the pin controllers.
module cmd_dispatcher
  import mecobo_pkg::*;
#(
  parameter int LATE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  cmd_fifo_data_out,
  output logic              cmd_fifo_rd_en,
  input  logic              cmd_fifo_empty,
  input  logic [31:0]       global_clock,
  input  logic              flush,
  output logic [7:0]        out_addr,
  output logic [7:0]        out_cmd,
  output logic [31:0]       out_data,
  output logic              out_wr,
  input  logic              out_busy,
  output logic              pending,
  output logic [LATE_W-1:0] late_count
);

  dispatch_state_t    state_q;
  logic [7:0]         addr_q;
  logic [7:0]         op_q;
  logic [31:0]        time_q;
  logic [31:0]        data_q;
  logic               first_wait_q;
  logic [LATE_W-1:0]  late_q;

  logic               due;
  logic               late;

  sched_time_cmp u_time_cmp (
    .global_clock_i (global_clock),
    .start_time_i   (time_q),
    .due_o          (due),
    .late_o         (late)
  );

  // Pop and strobe are combinational so the FIFO read and the target write
  // land in the same cycle the FSM decides them; flush and reset veto both.
  always_comb begin
    cmd_fifo_rd_en = (state_q == ST_IDLE) && !cmd_fifo_empty && !flush && !rst;
    out_wr         = (state_q == ST_DISPATCH) && !out_busy && !flush && !rst;
  end

  // Dispatcher FSM together with the held command fields and late counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      op_q         <= '0;
      time_q       <= '0;
      data_q       <= '0;
      first_wait_q <= 1'b0;
      late_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!cmd_fifo_empty && !flush) begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else begin
            addr_q       <= cmd_fifo_data_out[CMD_ADDR_HI:CMD_ADDR_LO];
            op_q         <= cmd_fifo_data_out[CMD_OP_HI:CMD_OP_LO];
            time_q       <= cmd_fifo_data_out[CMD_TIME_HI:CMD_TIME_LO];
            data_q       <= cmd_fifo_data_out[CMD_DATA_HI:CMD_DATA_LO];
            first_wait_q <= 1'b1;
            if (cmd_fifo_data_out[CMD_OP_HI:CMD_OP_LO] == OP_NOP) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          first_wait_q <= 1'b0;
          // Lateness is judged only on arrival in WAIT, and saturates.
          if (first_wait_q && late && (late_q != {LATE_W{1'b1}})) begin
            late_q <= late_q + 1'b1;
          end
          if (flush) begin
            state_q <= ST_IDLE;
          end else if (due) begin
            state_q <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          if (flush || !out_busy) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_addr   = addr_q;
  assign out_cmd    = op_q;
  assign out_data   = data_q;
  assign pending    = (state_q != ST_IDLE);
  assign late_count = late_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed bench for cmd_dispatcher: bench-side FIFO model, scoreboard of
// expected dispatches, and a per-cycle monitor for strobe/pop rules.
module tb_cmd_dispatcher;
  import mecobo_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [79:0] cmd_fifo_data_out = '0;
  logic        cmd_fifo_rd_en;
  logic        cmd_fifo_empty = 1'b1;
  logic [31:0] global_clock = '0;
  logic        flush = 1'b0;
  logic [7:0]  out_addr;
  logic [7:0]  out_cmd;
  logic [31:0] out_data;
  logic        out_wr;
  logic        out_busy = 1'b0;
  logic        pending;
  logic [15:0] late_count;

  cmd_dispatcher #(.LATE_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_fifo_data_out (cmd_fifo_data_out),
    .cmd_fifo_rd_en    (cmd_fifo_rd_en),
    .cmd_fifo_empty    (cmd_fifo_empty),
    .global_clock      (global_clock),
    .flush             (flush),
    .out_addr          (out_addr),
    .out_cmd           (out_cmd),
    .out_data          (out_data),
    .out_wr            (out_wr),
    .out_busy          (out_busy),
    .pending           (pending),
    .late_count        (late_count)
  );

  always #5 clk = ~clk;

  logic [79:0] fifo_q[$];
  logic [47:0] sb_q[$];
  int          wr_cycs[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  int          last_rd_cyc = -1;
  int          last_wr_cyc = -1;
  logic [31:0] gc_at_wr = '0;
  logic        prev_wr = 1'b0;
  bit          gc_run = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: monitor outputs before the edge, then model FIFO/time.
  task automatic cycle();
    logic        rd_pre;
    logic        wr_pre;
    logic [47:0] e;
    #1;
    rd_pre = cmd_fifo_rd_en;
    wr_pre = out_wr;
    if (rd_pre) begin
      chk("rd_while_empty", 64'(cmd_fifo_empty), 64'd0);
      rd_count++;
      last_rd_cyc = cyc;
    end
    if (wr_pre) begin
      chk("wr_back_to_back", 64'(prev_wr), 64'd0);
      wr_count++;
      last_wr_cyc = cyc;
      gc_at_wr = global_clock;
      wr_cycs.push_back(cyc);
      if (sb_q.size() == 0) begin
        chk("wr_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("wr_fields", 64'({out_addr, out_cmd, out_data}), 64'(e));
      end
    end
    prev_wr = wr_pre;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_pre && fifo_q.size() > 0) cmd_fifo_data_out = fifo_q.pop_front();
    cmd_fifo_empty = (fifo_q.size() == 0);
    if (gc_run) global_clock = global_clock + 32'd1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] op,
                      input logic [31:0] t, input logic [31:0] d);
    fifo_q.push_back({a, op, t, d});
    if (op != OP_NOP) sb_q.push_back({a, op, d});
    cmd_fifo_empty = 1'b0;
  endtask

  task automatic wait_wr(input string tag, input int budget);
    int w0 = wr_count;
    for (int i = 0; i < budget && wr_count == w0; i++) cycle();
    chk(tag, 64'(wr_count != w0), 64'd1);
  endtask

  task automatic wait_rd(input string tag, input int budget);
    int r0 = rd_count;
    for (int i = 0; i < budget && rd_count == r0; i++) cycle();
    chk(tag, 64'(rd_count != r0), 64'd1);
  endtask

  initial begin
    int  r0;
    int  w0;
    bit  stable;

    // Reset values
    rst = 1'b1;
    run(3);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_rd_en", 64'(cmd_fifo_rd_en), 64'd0);
    chk("rst_fields", 64'({out_addr, out_cmd, out_data}), 64'd0);
    chk("rst_late", 64'(late_count), 64'd0);
    rst = 1'b0;

    // Immediate command
    gc_run = 1'b1;
    global_clock = 32'd1000;
    push(8'h03, 8'h10, 32'd0, 32'hCAFEBABE);
    wait_wr("imm_timeout", 10);
    chk("imm_latency", 64'(last_wr_cyc - last_rd_cyc), 64'd3);
    chk("imm_late", 64'(late_count), 64'd0);
    run(2);

    // Scheduled command
    global_clock = 32'd100;
    push(8'h04, 8'h11, 32'd200, 32'h0000_0200);
    wait_wr("sched_timeout", 200);
    chk("sched_gc_at_wr", 64'(gc_at_wr), 64'd201);
    chk("sched_late", 64'(late_count), 64'd0);
    run(2);

    // Late command: enters WAIT at clock 80 with start 50
    global_clock = 32'd78;
    push(8'h07, 8'h12, 32'd50, 32'h0000_0055);
    wait_wr("late_timeout", 10);
    chk("late_gc_at_wr", 64'(gc_at_wr), 64'd81);
    chk("late_count_1", 64'(late_count), 64'd1);
    run(2);

    // Wrap: start 0x10 seen from just below the wrap point
    global_clock = 32'hFFFF_FFF0;
    push(8'h08, 8'h13, 32'h0000_0010, 32'h0000_0066);
    wait_wr("wrap_timeout", 64);
    chk("wrap_gc_at_wr", 64'(gc_at_wr), 64'h11);
    chk("wrap_late", 64'(late_count), 64'd1);
    run(2);

    // NOP followed by three immediate commands
    wr_cycs.delete();
    r0 = rd_count;
    w0 = wr_count;
    push(8'h09, OP_NOP, 32'd0, 32'h0000_0000);
    push(8'h0A, 8'h21, 32'd0, 32'h1111_1111);
    push(8'h0B, 8'h22, 32'd0, 32'h2222_2222);
    push(8'h0C, 8'h23, 32'd0, 32'h3333_3333);
    run(25);
    chk("b2b_rd_pulses", 64'(rd_count - r0), 64'd4);
    chk("b2b_wr_pulses", 64'(wr_count - w0), 64'd3);
    if (wr_cycs.size() == 3) begin
      chk("b2b_gap_1", 64'(wr_cycs[1] - wr_cycs[0]), 64'd4);
      chk("b2b_gap_2", 64'(wr_cycs[2] - wr_cycs[1]), 64'd4);
    end

    // Backpressure: busy held for 10 DISPATCH cycles
    out_busy = 1'b1;
    push(8'h05, 8'h30, 32'd0, 32'hDEADBEEF);
    wait_rd("busy_rd_timeout", 10);
    run(2);
    w0 = wr_count;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (out_addr !== 8'h05 || out_cmd !== 8'h30 || out_data !== 32'hDEADBEEF) stable = 1'b0;
    end
    chk("busy_fields_stable", 64'(stable), 64'd1);
    chk("busy_no_wr", 64'(wr_count - w0), 64'd0);
    chk("busy_pending", 64'(pending), 64'd1);
    out_busy = 1'b0;
    cycle();
    chk("busy_release_wr", 64'(last_wr_cyc), 64'(cyc - 1));
    chk("busy_idle_after", 64'(pending), 64'd0);

    // Flush while waiting on a future start time (time frozen)
    gc_run = 1'b0;
    global_clock = 32'd500;
    push(8'h06, 8'h31, 32'd1000, 32'h0BAD_F00D);
    wait_rd("flush_rd_timeout", 10);
    run(3);
    chk("flush_pending_before", 64'(pending), 64'd1);
    w0 = wr_count;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_pending_after", 64'(pending), 64'd0);
    void'(sb_q.pop_back());
    run(5);
    chk("flush_no_wr", 64'(wr_count - w0), 64'd0);

    // Reset while WAITing; the following word must still be popped
    push(8'h0D, 8'h40, 32'd1000, 32'h4444_4444);
    push(8'h0E, 8'h41, 32'd0, 32'h1234_5678);
    wait_rd("rstw_rd_timeout", 10);
    run(3);
    rst = 1'b1;
    cycle();
    #1;
    chk("rstw_pending", 64'(pending), 64'd0);
    chk("rstw_fields", 64'({out_addr, out_cmd, out_data}), 64'd0);
    chk("rstw_late", 64'(late_count), 64'd0);
    chk("rstw_out_wr", 64'(out_wr), 64'd0);
    chk("rstw_rd_en", 64'(cmd_fifo_rd_en), 64'd0);
    void'(sb_q.pop_front());
    rst = 1'b0;
    gc_run = 1'b1;
    r0 = rd_count;
    wait_wr("rstw_next_timeout", 10);
    chk("rstw_single_pop", 64'(rd_count - r0), 64'd1);
    run(2);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
